lt24_pixel_writer: RTL and testbench
====================================

// Module: lt24_pixel_writer
// PURPOSE
//  Responder end of the pixel interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady) driven by ChessEngine-style renderers.
//  Accepts one pixel per handshake and serialises it onto the LT24 (ILI9341) 8080-style 16-bit write bus.
//  Issues column (0x2A), page (0x2B) and memory-write (0x2C) commands. Sits between the renderer and the LT24 pins, after the init sequencer.
// PARAMETERS
//  WR_LOW_CYCLES   2    clocks LT24Wr_n held low per bus word (>=1)
//  WR_HIGH_CYCLES  2    clocks LT24Wr_n held high per bus word (>=1)
//  LCD_WIDTH       240  columns; valid x = 0..LCD_WIDTH-1
//  LCD_HEIGHT      320  rows; valid y = 0..LCD_HEIGHT-1
// PORTS
//  clock        in   1   system clock; all state changes on rising edge
//  resetApp     in   1   asynchronous, active-high reset
//  initDone     in   1   panel init complete; no pixel accepted while low
//  xAddr        in   8   pixel column
//  yAddr        in   9   pixel row
//  pixelData    in   16  RGB565 colour
//  pixelWrite   in   1   requester has a valid pixel
//  pixelReady   out  1   responder can accept; transfer = pixelWrite & pixelReady at rising edge
//  LT24Wr_n     out  1   write strobe, active low; data latched by panel on rising edge
//  LT24Rd_n     out  1   tied high (no reads)
//  LT24CS_n     out  1   chip select, active low while a word sequence is in progress
//  LT24RS       out  1   0 = command word, 1 = data word
//  LT24Data     out  16  bus word; commands/params in [7:0], [15:8] = 0
// BEHAVIOUR
//  Reset values: pixelReady=0, LT24Wr_n=1, LT24Rd_n=1, LT24CS_n=1, LT24RS=1, LT24Data=0.
//  Reset also clears the stream state (streamValid=0, lastX=0, lastY=0, winX=0).
//  Reset mid-sequence abandons the sequence; the next accepted pixel always uses a full sequence.
//  FSM states: IDLE, WR_LOW, WR_HIGH, DROP.
//   IDLE:    pixelReady = initDone, registered. CS_n=1, Wr_n=1. initDone is sampled only in IDLE.
//            On transfer with an out-of-range x or y -> DROP. Otherwise, on transfer -> WR_LOW with word 0 driven.
//   DROP:    pixelReady=0 for one cycle; clear streamValid; -> IDLE.
//   WR_LOW:  CS_n=0, Wr_n=0. LT24RS/LT24Data for the current word are set at the same edge Wr_n falls and held through WR_HIGH.
//            Lasts WR_LOW_CYCLES cycles -> WR_HIGH.
//   WR_HIGH: Wr_n=1 for WR_HIGH_CYCLES cycles.
//            If more words remain: advance word index -> WR_LOW. After the last word -> IDLE, with pixelReady=1 the same edge.
//  Full sequence (N=12), with RS in parentheses:
//   2A(0), 00(1), x(1), 00(1), EF(1),
//   2B(0), {7'b0,y[8]}(1), y[7:0](1), 01(1), 3F(1),
//   2C(0), pixelData(1).
//   After a full sequence: winX<=x.
//  Streamed sequence (N=1): pixelData(1) only. Relies on the panel's memory-write auto-increment.
//  Throughput: with a transfer at edge T, pixelReady next rises at edge T+N*(WR_LOW_CYCLES+WR_HIGH_CYCLES).
//   Defaults: 48 cycles for a full sequence, 4 cycles streamed.
//  On every accepted in-range pixel: lastX<=x, lastY<=y, streamValid<=1.
//  Width rules: y[8] is zero-extended to a byte. Range compares use 9-bit unsigned arithmetic. No arithmetic wraps in the x/y registers.
//  Simultaneous pixelWrite while pixelReady=0 is ignored (no queueing). Data is captured only at the transfer edge.
// CONFIGURATION
//  LT24_STREAM_OPT_EN defined: use the streamed sequence when streamValid and either:
//   (x==lastX+1 && y==lastY && lastX<LCD_WIDTH-1), or
//   (lastX==LCD_WIDTH-1 && x==winX && y==lastY+1 && lastY<LCD_HEIGHT-1).
//   Otherwise use the full sequence.
//  LT24_STREAM_OPT_EN undefined: every pixel uses the full sequence; streamValid logic is removed.
// STRUCTURE
//  Package lt24_pkg: CMD_COL_SET=8'h2A, CMD_PAGE_SET=8'h2B, CMD_MEM_WRITE=8'h2C.
//   Also LCD_WIDTH/LCD_HEIGHT defaults, the FSM state encoding, and the word-index width.
//  Sub-module lt24_bus_strobe: given start/rs/data, drives Wr_n low then high for the programmed cycle counts and pulses done.
//   The parent FSM sequences words through it.
// TESTING
//  1 Reset: hold resetApp with pixelWrite=1 -> pixelReady=0, Wr_n=CS_n=Rd_n=RS=1, Data=0. No strobes until initDone=1.
//  2 Single pixel x=5,y=300,data=16'hF800 -> exactly 12 Wr_n pulses:
//    2A,00,05,00,EF,2B,01,2C,01,3F,2C,F800 with RS 0,1,1,1,1,0,1,1,1,1,0,1.
//    pixelReady returns 48 cycles after the transfer.
//  3 (STREAM_OPT_EN) Raster pixels (0,40),(1,40),...,(239,40),(0,41) -> the first pixel gets 12 words, all others 1 word each.
//    Pixel (10,40) after (239,41) -> 12 words.
//  4 Out-of-range x=240 or y=320 -> no Wr_n pulse, pixelReady low 1 cycle.
//    The next in-range pixel always gets a full sequence.
//  5 Assert resetApp during word 6 of a full sequence -> outputs go to reset values asynchronously.
//    After release, pixel (1,40) following (0,40) still gets a full 12-word sequence.
//  6 Timing: WR_LOW_CYCLES=3, WR_HIGH_CYCLES=1 -> Wr_n low exactly 3 cycles per word.
//    RS/Data stable over the whole low+high window; full sequence = 48 cycles.

Source files
------------

// File: rtl/lt24_pkg.sv
// Shared constants, state encodings and the bus-word table for the LT24 pixel writer.
package lt24_pkg;

    localparam logic [7:0] CMD_COL_SET   = 8'h2A;
    localparam logic [7:0] CMD_PAGE_SET  = 8'h2B;
    localparam logic [7:0] CMD_MEM_WRITE = 8'h2C;

    localparam int unsigned LCD_WIDTH_DEF  = 240;
    localparam int unsigned LCD_HEIGHT_DEF = 320;

    localparam int unsigned WORD_IDX_W = 4;
    localparam int unsigned SEQ_WORDS  = 12;
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(SEQ_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_LOW,
        WR_HIGH,
        DROP
    } wrState_t;

    typedef enum logic [1:0] {
        STB_IDLE,
        STB_LOW,
        STB_HIGH
    } strobeState_t;

    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } busWord_t;

    // Word idx of the full window-set + memory-write sequence; the last word is always the pixel.
    function automatic busWord_t seqWord(
        input logic [WORD_IDX_W-1:0] idx,
        input logic [7:0]            x,
        input logic [8:0]            y,
        input logic [15:0]           pixel,
        input logic [15:0]           colEnd,
        input logic [15:0]           pageEnd
    );
        busWord_t w;
        w.rs   = 1'b1;
        w.data = '0;
        case (int'(idx))
            0:  begin w.rs = 1'b0; w.data = {8'h00, CMD_COL_SET}; end
            1:  w.data = '0;
            2:  w.data = {8'h00, x};
            3:  w.data = {8'h00, colEnd[15:8]};
            4:  w.data = {8'h00, colEnd[7:0]};
            5:  begin w.rs = 1'b0; w.data = {8'h00, CMD_PAGE_SET}; end
            6:  w.data = {8'h00, 7'b0, y[8]};
            7:  w.data = {8'h00, y[7:0]};
            8:  w.data = {8'h00, pageEnd[15:8]};
            9:  w.data = {8'h00, pageEnd[7:0]};
            10: begin w.rs = 1'b0; w.data = {8'h00, CMD_MEM_WRITE}; end
            11: w.data = pixel;
            default: w.data = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_pixel_writer_if.sv
// Renderer-to-writer pixel handshake; a transfer is pixelWrite & pixelReady at a rising clock edge.
interface lt24_pixel_writer_if;

    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;

    modport master (
        output xAddr,
        output yAddr,
        output pixelData,
        output pixelWrite,
        input  pixelReady
    );

    modport slave (
        input  xAddr,
        input  yAddr,
        input  pixelData,
        input  pixelWrite,
        output pixelReady
    );

endinterface

// File: rtl/lt24_bus_strobe.sv
// One 8080-style write cycle: latches rs/data on start, holds Wr_n low then high for the programmed counts.
module lt24_bus_strobe
    import lt24_pkg::*;
#(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetApp,
    input  logic        start,
    input  busWord_t    word,
    output logic        wrN,
    output logic        rs,
    output logic [15:0] data,
    output logic        lowDone,
    output logic        done
);

    localparam int unsigned MAX_CYCLES = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYCLES - 1);

    strobeState_t  phase;
    logic [CW-1:0] cnt;

    // Flags are valid in the final cycle of each phase so the parent can chain the next word without a gap.
    assign lowDone = (phase == STB_LOW)  && (cnt == LOW_LAST);
    assign done    = (phase == STB_HIGH) && (cnt == HIGH_LAST);

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            phase <= STB_IDLE;
            cnt   <= '0;
            wrN   <= 1'b1;
            rs    <= 1'b1;
            data  <= '0;
        end else if (start) begin
            phase <= STB_LOW;
            cnt   <= '0;
            wrN   <= 1'b0;
            rs    <= word.rs;
            data  <= word.data;
        end else begin
            case (phase)
                STB_LOW: begin
                    if (lowDone) begin
                        phase <= STB_HIGH;
                        cnt   <= '0;
                        wrN   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STB_HIGH: begin
                    if (done) begin
                        phase <= STB_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/lt24_pixel_writer.sv
// Accepts pixels from a renderer and writes them to the LT24 via column/page/memory-write sequences.
// Optional LT24_STREAM_OPT_EN: skip the window commands for raster-contiguous pixels.
module lt24_pixel_writer
    import lt24_pkg::*;
#(
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 2,
    parameter int unsigned LCD_WIDTH      = LCD_WIDTH_DEF,
    parameter int unsigned LCD_HEIGHT     = LCD_HEIGHT_DEF
) (
    input  logic                 clock,
    input  logic                 resetApp,
    input  logic                 initDone,
    lt24_pixel_writer_if.slave   pixelIf,
    output logic                 LT24Wr_n,
    output logic                 LT24Rd_n,
    output logic                 LT24CS_n,
    output logic                 LT24RS,
    output logic [15:0]          LT24Data
);

    localparam logic [8:0]  X_LIMIT  = 9'(LCD_WIDTH);
    localparam logic [8:0]  Y_LIMIT  = 9'(LCD_HEIGHT);
    localparam logic [15:0] COL_END  = 16'(LCD_WIDTH - 1);
    localparam logic [15:0] PAGE_END = 16'(LCD_HEIGHT - 1);

    wrState_t              state;
    logic                  pixelReadyReg;
    logic [WORD_IDX_W-1:0] wordIdx;
    logic [WORD_IDX_W-1:0] startIdx;
    logic [7:0]            curX;
    logic [8:0]            curY;
    logic [15:0]           curPixel;
    logic                  transfer;
    logic                  inRange;
    logic                  useStream;
    logic                  start;
    logic                  strobeLowDone;
    logic                  strobeDone;
    busWord_t              startWord;

    assign pixelIf.pixelReady = pixelReadyReg;
    assign LT24Rd_n = 1'b1;

    assign transfer = (state == IDLE) && pixelIf.pixelWrite && pixelReadyReg;
    assign inRange  = ({1'b0, pixelIf.xAddr} < X_LIMIT) && (pixelIf.yAddr < Y_LIMIT);

`ifdef LT24_STREAM_OPT_EN
    localparam logic [8:0] X_LAST = 9'(LCD_WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);

    logic       streamValid;
    logic [7:0] lastX;
    logic [7:0] winX;
    logic [8:0] lastY;

    // Comparisons are widened by one bit so lastX+1 / lastY+1 can never wrap onto a valid coordinate.
    assign useStream = streamValid && (
        (({1'b0, pixelIf.xAddr} == {1'b0, lastX} + 9'd1) && (pixelIf.yAddr == lastY) && ({1'b0, lastX} < X_LAST)) ||
        (({1'b0, lastX} == X_LAST) && (pixelIf.xAddr == winX) &&
         ({1'b0, pixelIf.yAddr} == {1'b0, lastY} + 10'd1) && (lastY < Y_LAST)));

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            streamValid <= 1'b0;
            lastX       <= '0;
            lastY       <= '0;
            winX        <= '0;
        end else if (transfer && inRange) begin
            streamValid <= 1'b1;
            lastX       <= pixelIf.xAddr;
            lastY       <= pixelIf.yAddr;
            if (!useStream) begin
                winX <= pixelIf.xAddr;
            end
        end else if (state == DROP) begin
            streamValid <= 1'b0;
        end
    end
`else
    assign useStream = 1'b0;
`endif

    // A streamed pixel enters the sequence at the final (pixel data) word.
    assign startIdx = useStream ? LAST_WORD : '0;

    always_comb begin
        if (state == IDLE) begin
            startWord = seqWord(startIdx, pixelIf.xAddr, pixelIf.yAddr, pixelIf.pixelData, COL_END, PAGE_END);
        end else begin
            startWord = seqWord(wordIdx + WORD_IDX_W'(1), curX, curY, curPixel, COL_END, PAGE_END);
        end
    end

    assign start = (transfer && inRange) ||
                   ((state == WR_HIGH) && strobeDone && (wordIdx != LAST_WORD));

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state         <= IDLE;
            pixelReadyReg <= 1'b0;
            LT24CS_n      <= 1'b1;
            wordIdx       <= '0;
            curX          <= '0;
            curY          <= '0;
            curPixel      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pixelReadyReg <= initDone;
                    LT24CS_n      <= 1'b1;
                    if (transfer) begin
                        pixelReadyReg <= 1'b0;
                        if (!inRange) begin
                            state <= DROP;
                        end else begin
                            state    <= WR_LOW;
                            LT24CS_n <= 1'b0;
                            wordIdx  <= startIdx;
                            curX     <= pixelIf.xAddr;
                            curY     <= pixelIf.yAddr;
                            curPixel <= pixelIf.pixelData;
                        end
                    end
                end
                WR_LOW: begin
                    if (strobeLowDone) begin
                        state <= WR_HIGH;
                    end
                end
                WR_HIGH: begin
                    if (strobeDone) begin
                        if (wordIdx == LAST_WORD) begin
                            state         <= IDLE;
                            pixelReadyReg <= 1'b1;
                            LT24CS_n      <= 1'b1;
                        end else begin
                            state   <= WR_LOW;
                            wordIdx <= wordIdx + WORD_IDX_W'(1);
                        end
                    end
                end
                DROP: begin
                    state         <= IDLE;
                    pixelReadyReg <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    lt24_bus_strobe #(
        .WR_LOW_CYCLES  (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
    ) u_strobe (
        .clock    (clock),
        .resetApp (resetApp),
        .start    (start),
        .word     (startWord),
        .wrN      (LT24Wr_n),
        .rs       (LT24RS),
        .data     (LT24Data),
        .lowDone  (strobeLowDone),
        .done     (strobeDone)
    );

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Randomised bench for lt24_pixel_writer: a timeline model predicts every output on every cycle.
module tb_lt24_pixel_writer;

    localparam int L  = 3;
    localparam int H  = 1;
    localparam int P  = L + H;
    localparam int W  = 240;
    localparam int HT = 320;
`ifdef LT24_STREAM_OPT_EN
    localparam int STREAM_WORDS = 1;
`else
    localparam int STREAM_WORDS = 12;
`endif

    logic        clock = 1'b0;
    logic        resetApp = 1'b1;
    logic        initDone = 1'b0;
    logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
    logic [15:0] LT24Data;

    lt24_pixel_writer_if pif();

    lt24_pixel_writer #(
        .WR_LOW_CYCLES  (L),
        .WR_HIGH_CYCLES (H)
    ) dut (
        .clock    (clock),
        .resetApp (resetApp),
        .initDone (initDone),
        .pixelIf  (pif),
        .LT24Wr_n (LT24Wr_n),
        .LT24Rd_n (LT24Rd_n),
        .LT24CS_n (LT24CS_n),
        .LT24RS   (LT24RS),
        .LT24Data (LT24Data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int wrFalls = 0;

    always @(negedge LT24Wr_n) wrFalls <= wrFalls + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word k of the full sequence as the panel must see it: {rs, data}.
    function automatic logic [16:0] fullWord(input int k, input int x, input int y, input logic [15:0] d);
        case (k)
            0:  return {1'b0, 16'h002A};
            1:  return {1'b1, 16'h0000};
            2:  return {1'b1, 16'(x)};
            3:  return {1'b1, 16'(((W - 1) >> 8) & 255)};
            4:  return {1'b1, 16'((W - 1) & 255)};
            5:  return {1'b0, 16'h002B};
            6:  return {1'b1, 16'(y >> 8)};
            7:  return {1'b1, 16'(y & 255)};
            8:  return {1'b1, 16'(((HT - 1) >> 8) & 255)};
            9:  return {1'b1, 16'((HT - 1) & 255)};
            10: return {1'b0, 16'h002C};
            default: return {1'b1, d};
        endcase
    endfunction

    // Model state: a pixel's words occupy consecutive P-cycle slots starting at its transfer edge.
    bit          mSeq, mDrop, mReady, mValid;
    int          mT, mLastX, mLastY, mWinX;
    logic [16:0] mWords[$];
    logic        mRs;
    logic [15:0] mData;

    function automatic bit streamOk(input int x, input int y);
`ifdef LT24_STREAM_OPT_EN
        return mValid && ((x == mLastX + 1 && y == mLastY && mLastX < W - 1) ||
                          (mLastX == W - 1 && x == mWinX && y == mLastY + 1 && mLastY < HT - 1));
`else
        return (x < 0) && (y < 0) && mValid;
`endif
    endfunction

    initial begin : compare
        int x, y;
        logic [15:0] d;
        forever begin
            @(posedge clock);
            if (resetApp) begin
                mSeq = 0; mDrop = 0; mReady = 0; mValid = 0;
                mT = 0; mLastX = 0; mLastY = 0; mWinX = 0;
                mRs = 1'b1; mData = '0;
            end else if (mSeq) begin
                mT++;
                if (mT == mWords.size() * P) begin
                    mSeq = 0;
                    mReady = 1;
                end
            end else if (mDrop) begin
                mDrop = 0;
                mReady = 1;
            end else if (mReady && pif.pixelWrite) begin
                x = int'(pif.xAddr);
                y = int'(pif.yAddr);
                d = pif.pixelData;
                mReady = 0;
                if (x >= W || y >= HT) begin
                    mDrop = 1;
                    mValid = 0;
                end else begin
                    mWords.delete();
                    if (streamOk(x, y)) begin
                        mWords.push_back({1'b1, d});
                    end else begin
                        for (int k = 0; k < 12; k++) mWords.push_back(fullWord(k, x, y, d));
                        mWinX = x;
                    end
                    mLastX = x; mLastY = y; mValid = 1;
                    mSeq = 1; mT = 0;
                end
            end else begin
                mReady = initDone;
            end
            if (mSeq) {mRs, mData} = mWords[mT / P];
            #1;
            check("pixelReady", pif.pixelReady, mReady);
            check("LT24Wr_n", LT24Wr_n, (mSeq && (mT % P) < L) ? 1'b0 : 1'b1);
            check("LT24CS_n", LT24CS_n, mSeq ? 1'b0 : 1'b1);
            check("LT24Rd_n", LT24Rd_n, 1'b1);
            check("LT24RS", LT24RS, mRs);
            check("LT24Data", LT24Data, mData);
        end
    end

    initial begin : watchdog
        #20000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic sendPixel(input int x, input int y, input logic [15:0] d, output int words, output int lat);
        int f0;
        bit got;
        words = -1; lat = -1; got = 0;
        @(negedge clock);
        pif.xAddr = 8'(x); pif.yAddr = 9'(y); pif.pixelData = d; pif.pixelWrite = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (pif.pixelReady === 1'b1) begin got = 1; break; end
            @(negedge clock);
        end
        if (!got) begin
            check("xferTimeout", 0, 1);
            pif.pixelWrite = 1'b0;
            return;
        end
        f0 = wrFalls;
        @(posedge clock);
        #1;
        // Junk with pixelWrite held for one busy cycle: must be neither accepted nor captured.
        pif.xAddr = 8'($urandom); pif.yAddr = 9'($urandom_range(0, 319)); pif.pixelData = 16'($urandom);
        got = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clock);
            #1;
            if (i == 1) pif.pixelWrite = 1'b0;
            if (pif.pixelReady === 1'b1) begin lat = i; got = 1; break; end
        end
        if (!got) check("readyTimeout", 0, 1);
        words = wrFalls - f0;
    endtask

    initial begin : main
        int words, lat, f0, cx, cy, x, y, r;
        bit got;
        logic [16:0] pinTab [12];
        pinTab = '{17'h0002A, 17'h10000, 17'h10005, 17'h10000, 17'h100EF, 17'h0002B,
                   17'h10001, 17'h1002C, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};

        pif.xAddr = 8'd5; pif.yAddr = 9'd5; pif.pixelData = 16'h1234; pif.pixelWrite = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rstReady", pif.pixelReady, 1'b0);
        check("rstWr_n", LT24Wr_n, 1'b1);
        check("rstCS_n", LT24CS_n, 1'b1);
        check("rstRS", LT24RS, 1'b1);
        check("rstData", LT24Data, 16'h0000);

        @(negedge clock);
        resetApp = 1'b0;
        f0 = wrFalls;
        repeat (10) @(posedge clock);
        #1;
        check("noInitStrobes", wrFalls - f0, 0);
        check("noInitReady", pif.pixelReady, 1'b0);
        @(negedge clock);
        pif.pixelWrite = 1'b0;
        initDone = 1'b1;

        for (int k = 0; k < 12; k++) check("modelPin", fullWord(k, 5, 300, 16'hF800), pinTab[k]);

        sendPixel(5, 300, 16'hF800, words, lat);
        check("singleWords", words, 12);
        check("singleLatency", lat, 48);

        sendPixel(20, 10, 16'h07E0, words, lat);
        check("seqA", words, 12);
        sendPixel(21, 10, 16'h001F, words, lat);
        check("contA", words, STREAM_WORDS);
        sendPixel(240, 10, 16'hAAAA, words, lat);
        check("dropXWords", words, 0);
        check("dropXLatency", lat, 1);
        sendPixel(22, 10, 16'h5555, words, lat);
        check("afterDropX", words, 12);
        sendPixel(23, 320, 16'h1111, words, lat);
        check("dropYWords", words, 0);
        check("dropYLatency", lat, 1);
        sendPixel(23, 10, 16'h2222, words, lat);
        check("afterDropY", words, 12);

        // Reset during the sixth word of a full sequence.
        @(negedge clock);
        pif.xAddr = 8'd0; pif.yAddr = 9'd40; pif.pixelData = 16'hBEEF; pif.pixelWrite = 1'b1;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            if (pif.pixelReady === 1'b1) begin got = 1; break; end
            @(negedge clock);
        end
        check("midRstXfer", got, 1);
        @(posedge clock);
        #1;
        pif.pixelWrite = 1'b0;
        repeat (5 * P) @(posedge clock);
        #3;
        resetApp = 1'b1;
        #1;
        check("midRstWr_n", LT24Wr_n, 1'b1);
        check("midRstCS_n", LT24CS_n, 1'b1);
        check("midRstRS", LT24RS, 1'b1);
        check("midRstData", LT24Data, 16'h0000);
        check("midRstReady", pif.pixelReady, 1'b0);
        @(negedge clock);
        @(negedge clock);
        resetApp = 1'b0;
        sendPixel(1, 40, 16'hCAFE, words, lat);
        check("afterRstFull", words, 12);
        check("afterRstLatency", lat, 48);

        // Raster over two rows, then a jump back.
        f0 = wrFalls;
        for (int yy = 40; yy <= 41; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                sendPixel(xx, yy, 16'($urandom), words, lat);
            end
        end
        check("rasterWords", wrFalls - f0, 12 + 479 * STREAM_WORDS);
        sendPixel(10, 40, 16'h0F0F, words, lat);
        check("jumpBackFull", words, 12);

        cx = 10; cy = 40;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = 240 + int'($urandom_range(0, 15)); y = cy;
                end else begin
                    x = cx; y = 320 + int'($urandom_range(0, 191));
                end
            end else if (r <= 5) begin
                if (cx < W - 1) begin
                    x = cx + 1; y = cy;
                end else begin
                    x = 0; y = (cy < HT - 1) ? cy + 1 : 0;
                end
            end else begin
                x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 239)) : int'($urandom_range(230, 239));
                y = int'($urandom_range(0, 319));
            end
            sendPixel(x, y, 16'($urandom), words, lat);
            if (x < W && y < HT) begin
                cx = x; cy = y;
            end
        end

        repeat (4) @(posedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
